// File: rtl/multicycle_control.sv
// RV32I multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared memory port.
// Latency 3-5 cycles per instruction; stalls in FETCH/MEM while mem_ready is low, controls held stable.
module multicycle_control #(
  parameter bit RESET_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [1:0]  mem_size,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [3:0]  alu_ctl,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        rd_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEM       = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] TRAP      = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic [2:0] state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       is_store;
  logic [3:0] alu_ctl_e;
  logic [1:0] alu_a_e;
  logic       alu_b_e;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign is_store     = (opcode == OP_STORE);
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  // Legality and ALU setup; illegal encodings get all-zero ALU controls.
  always_comb begin
    legal     = 1'b0;
    alu_ctl_e = 4'd0;
    alu_a_e   = 2'd0;
    alu_b_e   = 1'b0;
    case (opcode)
      OP_ALU: begin
        legal     = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        alu_ctl_e = {funct7[5], funct3};
      end
      OP_IMM: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal = 1'b1;
        alu_ctl_e = {(funct3 == 3'b101) && funct7[5], funct3};
        alu_b_e   = 1'b1;
      end
      OP_LUI: begin
        legal   = 1'b1;
        alu_a_e = 2'd2;
        alu_b_e = 1'b1;
      end
      OP_AUIPC, OP_JAL: begin
        legal   = 1'b1;
        alu_a_e = 2'd1;
        alu_b_e = 1'b1;
      end
      OP_JALR: begin
        legal   = (funct3 == 3'b000);
        alu_b_e = 1'b1;
      end
      OP_LOAD: begin
        legal   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        alu_b_e = 1'b1;
      end
      OP_STORE: begin
        legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        alu_b_e = 1'b1;
      end
      OP_BRANCH: begin
        legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
        alu_a_e = 2'd1;
        alu_b_e = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      alu_ctl_e = 4'd0;
      alu_a_e   = 2'd0;
      alu_b_e   = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_size     = 2'd0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_ctl      = 4'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    rd_we        = 1'b0;
    wb_sel       = 2'd0;
    illegal      = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        mem_size = 2'd2;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = (!legal && RESET_TRAP) ? TRAP : EXECUTE;
      EXECUTE: begin
        alu_ctl   = alu_ctl_e;
        alu_a_sel = alu_a_e;
        alu_b_sel = alu_b_e;
        if (!legal) begin
          // Only reachable with trapping disabled: retire as a NOP.
          pc_we   = 1'b1;
          state_d = FETCH;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = MEM;
            OP_BRANCH: begin
              pc_we   = 1'b1;
              pc_src  = {1'b0, br_taken};
              state_d = FETCH;
            end
            OP_JAL, OP_JALR: begin
              pc_we   = 1'b1;
              pc_src  = (opcode == OP_JALR) ? 2'd2 : 2'd1;
              rd_we   = 1'b1;
              wb_sel  = 2'd2;
              state_d = FETCH;
            end
            default: state_d = WRITEBACK;
          endcase
        end
      end
      MEM: begin
        alu_ctl      = alu_ctl_e;
        alu_a_sel    = alu_a_e;
        alu_b_sel    = alu_b_e;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        mem_size     = funct3[1:0];
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        alu_ctl   = alu_ctl_e;
        alu_a_sel = alu_a_e;
        alu_b_sel = alu_b_e;
        rd_we     = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
        pc_we     = 1'b1;
        state_d   = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: state_d = FETCH;
    endcase
    // Reset must kill an outstanding request in the same cycle.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      mem_size     = 2'd0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      alu_ctl      = 4'd0;
      alu_a_sel    = 2'd0;
      alu_b_sel    = 1'b0;
      rd_we        = 1'b0;
      wb_sel       = 2'd0;
      illegal      = 1'b0;
    end
  end

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle traces queued and compared each cycle.
module tb_multicycle_control;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, ST = 3'd5;
  localparam int K_WB = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JAL = 4, K_JALR = 5, K_NOP = 6;
  localparam logic [22:0] ALL  = 23'h7FFFFF;
  localparam logic [22:0] SZM  = 23'h018000;
  localparam logic [22:0] ALUM = 23'h0007F0;
  localparam logic [22:0] NOSZ = ALL & ~SZM;

  typedef struct {
    logic [31:0] instr;
    int          kind;
    logic [3:0]  alu;
    logic [1:0]  a;
    logic        b;
    int          fw;
    int          mw;
    logic        br;
  } ent_t;

  typedef struct packed {
    logic        rdy;
    logic [22:0] exp;
    logic [22:0] care;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready, br_taken;

  logic d_req, d_we, d_asel, d_irwe, d_pcwe, d_b, d_rdwe, d_ill;
  logic [1:0] d_sz, d_pcsrc, d_a, d_wb;
  logic [3:0] d_alu;
  logic [2:0] d_st;
  logic t_req, t_we, t_asel, t_irwe, t_pcwe, t_b, t_rdwe, t_ill;
  logic [1:0] t_sz, t_pcsrc, t_a, t_wb;
  logic [3:0] t_alu;
  logic [2:0] t_st;
  logic [22:0] dut_vec, trap_vec;

  int   total = 0;
  int   bad   = 0;
  cyc_t sbq[$];
  ent_t tbl[15];

  always #5 clk = ~clk;

  multicycle_control #(.RESET_TRAP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(d_req), .mem_we(d_we), .mem_addr_sel(d_asel), .mem_size(d_sz), .ir_we(d_irwe),
    .pc_we(d_pcwe), .pc_src(d_pcsrc), .alu_ctl(d_alu), .alu_a_sel(d_a), .alu_b_sel(d_b),
    .rd_we(d_rdwe), .wb_sel(d_wb), .illegal(d_ill), .state(d_st)
  );

  multicycle_control #(.RESET_TRAP(1'b1)) u_trap (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(t_req), .mem_we(t_we), .mem_addr_sel(t_asel), .mem_size(t_sz), .ir_we(t_irwe),
    .pc_we(t_pcwe), .pc_src(t_pcsrc), .alu_ctl(t_alu), .alu_a_sel(t_a), .alu_b_sel(t_b),
    .rd_we(t_rdwe), .wb_sel(t_wb), .illegal(t_ill), .state(t_st)
  );

  assign dut_vec  = {d_st, d_req, d_we, d_asel, d_sz, d_irwe, d_pcwe, d_pcsrc, d_alu, d_a, d_b, d_rdwe, d_wb, d_ill};
  assign trap_vec = {t_st, t_req, t_we, t_asel, t_sz, t_irwe, t_pcwe, t_pcsrc, t_alu, t_a, t_b, t_rdwe, t_wb, t_ill};

  function automatic logic [22:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic asel, input logic [1:0] sz, input logic irwe,
                                     input logic pcwe, input logic [1:0] pcsrc, input logic [3:0] alu,
                                     input logic [1:0] a, input logic b, input logic rdwe,
                                     input logic [1:0] wb, input logic ill);
    return {st, req, we, asel, sz, irwe, pcwe, pcsrc, alu, a, b, rdwe, wb, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic rdy, input logic [22:0] exp, input logic [22:0] care);
    cyc_t c;
    c.rdy  = rdy;
    c.exp  = exp;
    c.care = care;
    sbq.push_back(c);
  endtask

  task automatic build(input ent_t e);
    logic [1:0]  dsz;
    logic [22:0] ex, mm;
    dsz = e.instr[13:12];
    for (int i = 0; i < e.fw; i++)
      push(1'b0, mk(SF, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0), ALL);
    push(1'b1, mk(SF, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0), ALL);
    push(1'b0, mk(SD, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0), NOSZ & ~ALUM);
    ex = mk(SE, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, e.alu, e.a, e.b, 1'b0, 2'd0, 1'b0);
    case (e.kind)
      K_WB: begin
        push(1'b0, ex, NOSZ);
        push(1'b0, mk(SW, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0), NOSZ & ~ALUM);
      end
      K_LD, K_ST: begin
        push(1'b0, ex, NOSZ);
        mm = mk(SM, 1'b1, e.kind == K_ST, 1'b1, dsz, 1'b0, 1'b0, 2'd0, e.alu, e.a, e.b, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < e.mw; i++) push(1'b0, mm, ALL);
        if (e.kind == K_ST) begin
          push(1'b1, mm | mk(SF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0), ALL);
        end else begin
          push(1'b1, mm, ALL);
          push(1'b0, mk(SW, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0), NOSZ & ~ALUM);
        end
      end
      K_BR:   push(1'b0, ex | mk(SF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, {1'b0, e.br}, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0), NOSZ);
      K_JAL:  push(1'b0, ex | mk(SF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 4'd0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0), NOSZ);
      K_JALR: push(1'b0, ex | mk(SF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0), NOSZ);
      default:
        push(1'b0, mk(SE, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0), NOSZ & ~ALUM);
    endcase
  endtask

  // Called right after a falling edge; drives one cycle per queued entry.
  task automatic run_ent(input int idx, input bit trap_chk);
    cyc_t c;
    int   n;
    n        = 0;
    build(tbl[idx]);
    instr    = tbl[idx].instr;
    br_taken = tbl[idx].br;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      mem_ready = c.rdy;
      #2;
      check($sformatf("e%0d.c%0d dut", idx, n), {9'd0, dut_vec & c.care}, {9'd0, c.exp & c.care});
      if (trap_chk)
        check($sformatf("e%0d.c%0d trapinst", idx, n), {9'd0, trap_vec & c.care}, {9'd0, c.exp & c.care});
      n++;
      @(negedge clk);
    end
  endtask

  task automatic hold_trap(input string tag);
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'b0;
      #2;
      check({tag, " trap"}, {9'd0, trap_vec},
            {9'd0, mk(ST, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1)});
      check({tag, " nop-fetch"}, {9'd0, dut_vec},
            {9'd0, mk(SF, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0)});
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0]  = '{32'h40208133, K_WB,   4'h8, 2'd0, 1'b0, 0, 0, 1'b0}; // sub
    tbl[1]  = '{32'h002081B3, K_WB,   4'h0, 2'd0, 1'b0, 3, 0, 1'b0}; // add, fetch wait 3
    tbl[2]  = '{32'h40335293, K_WB,   4'hD, 2'd0, 1'b1, 0, 0, 1'b0}; // srai
    tbl[3]  = '{32'hFFF14093, K_WB,   4'h4, 2'd0, 1'b1, 0, 0, 1'b0}; // xori -1
    tbl[4]  = '{32'h123450B7, K_WB,   4'h0, 2'd2, 1'b1, 0, 0, 1'b0}; // lui
    tbl[5]  = '{32'h00001097, K_WB,   4'h0, 2'd1, 1'b1, 0, 0, 1'b0}; // auipc
    tbl[6]  = '{32'h0040D283, K_LD,   4'h0, 2'd0, 1'b1, 0, 2, 1'b0}; // lhu, mem wait 2
    tbl[7]  = '{32'h0020A423, K_ST,   4'h0, 2'd0, 1'b1, 0, 1, 1'b0}; // sw
    tbl[8]  = '{32'h00208463, K_BR,   4'h0, 2'd1, 1'b1, 0, 0, 1'b1}; // beq taken
    tbl[9]  = '{32'h00208463, K_BR,   4'h0, 2'd1, 1'b1, 0, 0, 1'b0}; // beq not taken
    tbl[10] = '{32'h000100E7, K_JALR, 4'h0, 2'd0, 1'b1, 0, 0, 1'b0}; // jalr
    tbl[11] = '{32'h010000EF, K_JAL,  4'h0, 2'd1, 1'b1, 0, 0, 1'b0}; // jal
    tbl[12] = '{32'h0000007F, K_NOP,  4'h0, 2'd0, 1'b0, 0, 0, 1'b0}; // bad opcode
    tbl[13] = '{32'h4020F133, K_NOP,  4'h0, 2'd0, 1'b0, 0, 0, 1'b0}; // and with funct7=0x20
    tbl[14] = '{32'h002081B3, K_WB,   4'h0, 2'd0, 1'b0, 2, 0, 1'b0}; // add after reset

    rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; br_taken = 1'b0;
    #3;
    check("reset dut", {9'd0, dut_vec}, 32'd0);
    check("reset trapinst", {9'd0, trap_vec}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_ent(i, 1'b1);

    run_ent(12, 1'b0);
    hold_trap("op7f");
    rst = 1'b1;
    #2;
    check("pulse reset trapinst", {9'd0, trap_vec}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_ent(13, 1'b0);
    hold_trap("andf7");

    // Load into MEM wait, then reset asynchronously mid-cycle.
    instr = tbl[6].instr; br_taken = 1'b0;
    mem_ready = 1'b1; @(negedge clk);
    mem_ready = 1'b0; @(negedge clk);
    @(negedge clk);
    #2;
    check("mem wait state", {29'd0, d_st}, {29'd0, SM});
    check("mem wait req", {31'd0, d_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst mid-mem req", {31'd0, d_req}, 32'd0);
    check("rst mid-mem dut", {9'd0, dut_vec}, 32'd0);
    check("rst clears illegal", {31'd0, t_ill}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_ent(14, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
